// File: rtl/slice_demux_if.sv
// Pixel stream bundle for slice_demux: one raster input stream and
// MAX_NBR_SLICES per-slice output lanes, each with valid/ready handshake.
interface slice_demux_if #(
   parameter int MAX_NBR_SLICES = 2
);
   localparam int PIX_W = 4 * 3 * 14;

   logic [PIX_W-1:0]                pixs_in;
   logic                            pixs_in_valid;
   logic                            pixs_in_sof;
   logic                            pixs_in_ready;

   logic [MAX_NBR_SLICES*PIX_W-1:0] pixs_out_p;
   logic [MAX_NBR_SLICES-1:0]       pixs_out_valid;
   logic [MAX_NBR_SLICES-1:0]       pixs_out_ready;
   logic [MAX_NBR_SLICES-1:0]       pixs_out_sof;
   logic [MAX_NBR_SLICES-1:0]       pixs_out_sos;
   logic [MAX_NBR_SLICES-1:0]       pixs_out_eoc;
   logic [MAX_NBR_SLICES-1:0]       pixs_out_eof;

   // master: raster source and slice encoders; slave: the distributor
   modport master (
      output pixs_in, pixs_in_valid, pixs_in_sof, pixs_out_ready,
      input  pixs_in_ready, pixs_out_p, pixs_out_valid,
      input  pixs_out_sof, pixs_out_sos, pixs_out_eoc, pixs_out_eof
   );

   modport slave (
      input  pixs_in, pixs_in_valid, pixs_in_sof, pixs_out_ready,
      output pixs_in_ready, pixs_out_p, pixs_out_valid,
      output pixs_out_sof, pixs_out_sos, pixs_out_eoc, pixs_out_eof
   );
endinterface

// File: rtl/slice_demux.sv
// Raster-to-slice distributor: cuts each raster line into slice_width-pixel
// chunks and hands each chunk to the 1-deep output register of its slice lane.
module slice_demux #(
   parameter int MAX_NBR_SLICES   = 2,
   parameter int MAX_SLICE_WIDTH  = 2560,
   parameter int MAX_SLICE_HEIGHT = 2560
) (
   input  logic                                clk_core,
   input  logic                                rst_n,
   input  logic                                flush,
   input  logic [9:0]                          slices_per_line,
   input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]  slice_width,
   input  logic [$clog2(MAX_SLICE_HEIGHT)-1:0] slice_height,
   input  logic [15:0]                         frame_height,
   slice_demux_if.slave                        bus,
   output logic                                frame_done,
   output logic                                sof_err
);
   localparam int PIX_W = 4 * 3 * 14;
   localparam int SW_W  = $clog2(MAX_SLICE_WIDTH);
   localparam int SH_W  = $clog2(MAX_SLICE_HEIGHT);
   localparam int SEL_W = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t                          r_state;
   logic [SW_W-1:0]                 r_col;
   logic [SEL_W-1:0]                r_sel;
   logic [SH_W-1:0]                 r_sline;
   logic [15:0]                     r_fline;
   logic                            r_frame_done;
   logic                            r_sof_err;

   logic [MAX_NBR_SLICES*PIX_W-1:0] r_data;
   logic [MAX_NBR_SLICES-1:0]       r_vld;
   logic [MAX_NBR_SLICES-1:0]       r_sof;
   logic [MAX_NBR_SLICES-1:0]       r_sos;
   logic [MAX_NBR_SLICES-1:0]       r_eoc;
   logic [MAX_NBR_SLICES-1:0]       r_eof;

   logic                            w_acc;
   logic                            w_load;
   logic                            w_mid_sof;
   logic [SW_W-1:0]                 w_col;
   logic [SEL_W-1:0]                w_sel;
   logic [SH_W-1:0]                 w_sline;
   logic [15:0]                     w_fline;
   logic [SW_W-1:0]                 w_last_col;
   logic                            w_col_last;
   logic                            w_sel_last;
   logic                            w_sline_last;
   logic                            w_fline_last;
   logic                            w_frame_last;

   assign bus.pixs_in_ready = (r_state == S_IDLE) | ~r_vld[r_sel] | bus.pixs_out_ready[r_sel];

   // A sof word always restarts the raster position at 0/0/0, in IDLE or mid-frame.
   always_comb begin
      w_acc        = bus.pixs_in_valid & bus.pixs_in_ready;
      w_load       = w_acc & ((r_state == S_ACTIVE) | bus.pixs_in_sof);
      w_mid_sof    = w_acc & bus.pixs_in_sof & (r_state == S_ACTIVE) &
                     ((r_col != '0) | (r_sel != '0) | (r_sline != '0) | (r_fline != '0));
      w_col        = bus.pixs_in_sof ? '0 : r_col;
      w_sel        = bus.pixs_in_sof ? '0 : r_sel;
      w_sline      = bus.pixs_in_sof ? '0 : r_sline;
      w_fline      = bus.pixs_in_sof ? '0 : r_fline;
      w_last_col   = (slice_width >> 2) - SW_W'(1);
      w_col_last   = (w_col == w_last_col);
      w_sel_last   = (10'(w_sel) == slices_per_line - 10'd1);
      w_sline_last = (w_sline == slice_height - SH_W'(1));
      w_fline_last = (w_fline == frame_height - 16'd1);
      w_frame_last = w_col_last & w_sel_last & w_fline_last;
   end

   always_ff @(posedge clk_core or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_col        <= '0;
         r_sel        <= '0;
         r_sline      <= '0;
         r_fline      <= '0;
         r_frame_done <= 1'b0;
         r_sof_err    <= 1'b0;
      end else if (flush) begin
         r_state      <= S_IDLE;
         r_col        <= '0;
         r_sel        <= '0;
         r_sline      <= '0;
         r_fline      <= '0;
         r_frame_done <= 1'b0;
         r_sof_err    <= 1'b0;
      end else begin
         r_frame_done <= w_load & w_frame_last;
         if (w_mid_sof) begin
            r_sof_err <= 1'b1;
         end
         if (w_load) begin
            if (w_frame_last) begin
               r_state <= S_IDLE;
               r_col   <= '0;
               r_sel   <= '0;
               r_sline <= '0;
               r_fline <= '0;
            end else begin
               r_state <= S_ACTIVE;
               if (w_col_last) begin
                  r_col <= '0;
                  if (w_sel_last) begin
                     r_sel   <= '0;
                     r_sline <= w_sline_last ? '0 : w_sline + SH_W'(1);
                     r_fline <= w_fline + 16'd1;
                  end else begin
                     r_sel   <= w_sel + SEL_W'(1);
                     r_sline <= w_sline;
                     r_fline <= w_fline;
                  end
               end else begin
                  r_col   <= w_col + SW_W'(1);
                  r_sel   <= w_sel;
                  r_sline <= w_sline;
                  r_fline <= w_fline;
               end
            end
         end
      end
   end

   // Lane registers: load wins over drain, so a lane reloaded while being read stays valid.
   always_ff @(posedge clk_core or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_vld  <= '0;
         r_sof  <= '0;
         r_sos  <= '0;
         r_eoc  <= '0;
         r_eof  <= '0;
      end else if (flush) begin
         r_data <= '0;
         r_vld  <= '0;
         r_sof  <= '0;
         r_sos  <= '0;
         r_eoc  <= '0;
         r_eof  <= '0;
      end else begin
         for (int s = 0; s < MAX_NBR_SLICES; s++) begin
            if (w_load && (w_sel == SEL_W'(s))) begin
               r_data[s*PIX_W +: PIX_W] <= bus.pixs_in;
               r_vld[s] <= 1'b1;
               r_sof[s] <= (w_fline == '0) & (w_col == '0);
               r_sos[s] <= (w_sline == '0) & (w_col == '0);
               r_eoc[s] <= w_col_last;
               r_eof[s] <= w_fline_last & w_col_last;
            end else if (bus.pixs_out_ready[s]) begin
               r_vld[s] <= 1'b0;
            end
         end
      end
   end

   assign bus.pixs_out_p     = r_data;
   assign bus.pixs_out_valid = r_vld;
   assign bus.pixs_out_sof   = r_sof;
   assign bus.pixs_out_sos   = r_sos;
   assign bus.pixs_out_eoc   = r_eoc;
   assign bus.pixs_out_eof   = r_eof;
   assign frame_done         = r_frame_done;
   assign sof_err            = r_sof_err;

endmodule

// File: tb/tb_slice_demux.sv
// Bench for slice_demux: directed vector table, multi-cycle corner sequences,
// and randomized frames scored against a position-arithmetic reference model.
module tb_slice_demux;
   localparam int NS    = 2;
   localparam int PIX_W = 168;

   logic        clk_core = 1'b0;
   logic        rst_n    = 1'b0;
   logic        flush    = 1'b0;
   logic [9:0]  spl      = 10'd2;
   logic [11:0] sw       = 12'd8;
   logic [11:0] sh       = 12'd2;
   logic [15:0] fh       = 16'd2;
   logic        frame_done;
   logic        sof_err;

   slice_demux_if #(.MAX_NBR_SLICES(NS)) bus ();

   slice_demux #(.MAX_NBR_SLICES(NS), .MAX_SLICE_WIDTH(2560), .MAX_SLICE_HEIGHT(2560)) dut (
      .clk_core        (clk_core),
      .rst_n           (rst_n),
      .flush           (flush),
      .slices_per_line (spl),
      .slice_width     (sw),
      .slice_height    (sh),
      .frame_height    (fh),
      .bus             (bus),
      .frame_done      (frame_done),
      .sof_err         (sof_err)
   );

   always #5 clk_core = ~clk_core;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [9:0]  spl;
      logic [15:0] fh;
      logic        sof;
      int          lane;
      logic [3:0]  flg;   // {sof, sos, eoc, eof}
      logic        done;
      logic        err;
   } vec_t;

   typedef struct packed {
      logic [PIX_W-1:0] d;
      logic [3:0]       f;
   } exp_t;

   vec_t tbl [21];
   exp_t lq [NS][$];

   task automatic chk(input string nm, input logic [PIX_W-1:0] act, input logic [PIX_W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [PIX_W-1:0] rnd168();
      logic [191:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[PIX_W-1:0];
   endfunction

   function automatic logic [3:0] lane_flags(input int s);
      return {bus.pixs_out_sof[s], bus.pixs_out_sos[s], bus.pixs_out_eoc[s], bus.pixs_out_eof[s]};
   endfunction

   function automatic logic [PIX_W-1:0] lane_data(input int s);
      return bus.pixs_out_p[s*PIX_W +: PIX_W];
   endfunction

   task automatic send(input logic [PIX_W-1:0] d, input logic s);
      logic ok;
      ok = 1'b0;
      bus.pixs_in       = d;
      bus.pixs_in_sof   = s;
      bus.pixs_in_valid = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk_core);
         if (bus.pixs_in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         @(posedge clk_core);
         #1;
      end
      bus.pixs_in_valid = 1'b0;
      bus.pixs_in_sof   = 1'b0;
      chk("send_accepted", ok, 1);
   endtask

   task automatic chk_idle_outputs(input string nm);
      chk({nm, "_valid"}, bus.pixs_out_valid, 0);
      chk({nm, "_frame_done"}, frame_done, 0);
      chk({nm, "_sof_err"}, sof_err, 0);
      chk({nm, "_in_ready"}, bus.pixs_in_ready, 1);
   endtask

   task automatic run_random_frame();
      int cpw, nw, k, cyc, done_seen;
      logic [PIX_W-1:0] wd [$];
      logic avail;
      exp_t e;
      spl = 10'($urandom_range(1, NS));
      sw  = ($urandom_range(0, 1) != 0) ? 12'd16 : 12'd8;
      sh  = 12'($urandom_range(1, 3));
      fh  = 16'($urandom_range(1, 4));
      cpw = int'(sw) / 4;
      nw  = int'(spl) * cpw * int'(fh);
      for (int i = 0; i < nw; i++) begin
         int chunk, col, lane, line;
         col   = i % cpw;
         chunk = i / cpw;
         lane  = chunk % int'(spl);
         line  = chunk / int'(spl);
         e.d   = rnd168();
         e.f   = {line == 0 && col == 0, (line % int'(sh)) == 0 && col == 0,
                  col == cpw - 1, line == int'(fh) - 1 && col == cpw - 1};
         wd.push_back(e.d);
         lq[lane].push_back(e);
      end
      k = 0;
      cyc = 0;
      done_seen = 0;
      while ((k < nw || lq[0].size() != 0 || lq[1].size() != 0) && cyc < 4000) begin
         if (k < nw && !(k == 0 && bus.pixs_out_valid != '0) && $urandom_range(0, 3) != 0) begin
            bus.pixs_in_valid = 1'b1;
            bus.pixs_in       = wd[k];
            bus.pixs_in_sof   = (k == 0);
         end else begin
            bus.pixs_in_valid = 1'b0;
            bus.pixs_in_sof   = 1'b0;
         end
         for (int s = 0; s < NS; s++) bus.pixs_out_ready[s] = ($urandom_range(0, 9) < 7);
         @(negedge clk_core);
         for (int s = 0; s < NS; s++) begin
            if (bus.pixs_out_valid[s] && bus.pixs_out_ready[s]) begin
               avail = (lq[s].size() != 0);
               chk("rnd_word_expected", avail, 1);
               if (avail) begin
                  e = lq[s].pop_front();
                  chk("rnd_lane_data", lane_data(s), e.d);
                  chk("rnd_lane_flags", lane_flags(s), e.f);
               end
            end
         end
         if (bus.pixs_in_valid && bus.pixs_in_ready) k++;
         if (frame_done) done_seen++;
         @(posedge clk_core);
         #1;
         cyc++;
      end
      bus.pixs_in_valid = 1'b0;
      bus.pixs_in_sof   = 1'b0;
      chk("rnd_words_accepted", k, nw);
      chk("rnd_frame_done_count", done_seen, 1);
      lq[0].delete();
      lq[1].delete();
   endtask

   initial begin
      logic [PIX_W-1:0] w [8];
      logic [PIX_W-1:0] d;

      // spl, fh, sof, lane, {sof,sos,eoc,eof}, done, err
      tbl[0]  = '{10'd2, 16'd2, 1'b1, 0, 4'b1100, 1'b0, 1'b0};
      tbl[1]  = '{10'd2, 16'd2, 1'b0, 0, 4'b0010, 1'b0, 1'b0};
      tbl[2]  = '{10'd2, 16'd2, 1'b0, 1, 4'b1100, 1'b0, 1'b0};
      tbl[3]  = '{10'd2, 16'd2, 1'b0, 1, 4'b0010, 1'b0, 1'b0};
      tbl[4]  = '{10'd2, 16'd2, 1'b0, 0, 4'b0000, 1'b0, 1'b0};
      tbl[5]  = '{10'd2, 16'd2, 1'b0, 0, 4'b0011, 1'b0, 1'b0};
      tbl[6]  = '{10'd2, 16'd2, 1'b0, 1, 4'b0000, 1'b0, 1'b0};
      tbl[7]  = '{10'd2, 16'd2, 1'b0, 1, 4'b0011, 1'b1, 1'b0};
      tbl[8]  = '{10'd1, 16'd4, 1'b1, 0, 4'b1100, 1'b0, 1'b0};
      tbl[9]  = '{10'd1, 16'd4, 1'b0, 0, 4'b0010, 1'b0, 1'b0};
      tbl[10] = '{10'd1, 16'd4, 1'b0, 0, 4'b0000, 1'b0, 1'b0};
      tbl[11] = '{10'd1, 16'd4, 1'b0, 0, 4'b0010, 1'b0, 1'b0};
      tbl[12] = '{10'd1, 16'd4, 1'b0, 0, 4'b0100, 1'b0, 1'b0};
      tbl[13] = '{10'd1, 16'd4, 1'b0, 0, 4'b0010, 1'b0, 1'b0};
      tbl[14] = '{10'd1, 16'd4, 1'b0, 0, 4'b0000, 1'b0, 1'b0};
      tbl[15] = '{10'd1, 16'd4, 1'b0, 0, 4'b0011, 1'b1, 1'b0};
      tbl[16] = '{10'd2, 16'd2, 1'b1, 0, 4'b1100, 1'b0, 1'b0};
      tbl[17] = '{10'd2, 16'd2, 1'b0, 0, 4'b0010, 1'b0, 1'b0};
      tbl[18] = '{10'd2, 16'd2, 1'b0, 1, 4'b1100, 1'b0, 1'b0};
      tbl[19] = '{10'd2, 16'd2, 1'b1, 0, 4'b1100, 1'b0, 1'b1};
      tbl[20] = '{10'd2, 16'd2, 1'b0, 0, 4'b0010, 1'b0, 1'b1};

      bus.pixs_in        = '0;
      bus.pixs_in_valid  = 1'b0;
      bus.pixs_in_sof    = 1'b0;
      bus.pixs_out_ready = '1;

      #1;
      chk_idle_outputs("reset");
      repeat (2) @(posedge clk_core);
      #1;
      rst_n = 1'b1;
      @(posedge clk_core);
      #1;

      // Directed vectors: basic two-slice frame, single-slice frame, mid-frame sof.
      for (int i = 0; i < 21; i++) begin
         d = rnd168();
         spl = tbl[i].spl;
         fh  = tbl[i].fh;
         bus.pixs_in       = d;
         bus.pixs_in_sof   = tbl[i].sof;
         bus.pixs_in_valid = 1'b1;
         @(negedge clk_core);
         chk("tbl_in_ready", bus.pixs_in_ready, 1);
         @(posedge clk_core);
         #1;
         bus.pixs_in_valid = 1'b0;
         bus.pixs_in_sof   = 1'b0;
         chk("tbl_lane_valid", bus.pixs_out_valid[tbl[i].lane], 1);
         chk("tbl_lane_data", lane_data(tbl[i].lane), d);
         chk("tbl_lane_flags", lane_flags(tbl[i].lane), tbl[i].flg);
         for (int s = 0; s < NS; s++)
            if (s != tbl[i].lane) chk("tbl_other_lane_idle", bus.pixs_out_valid[s], 0);
         chk("tbl_frame_done", frame_done, tbl[i].done);
         chk("tbl_sof_err", sof_err, tbl[i].err);
      end

      // Flush mid-frame with lane 0 still holding a word.
      bus.pixs_out_ready = '0;
      @(posedge clk_core);
      #1;
      chk("pre_flush_hold", bus.pixs_out_valid[0], 1);
      flush = 1'b1;
      @(posedge clk_core);
      #1;
      flush = 1'b0;
      chk_idle_outputs("flush");

      // Back-pressure on lane 1 while it holds W2.
      spl = 10'd2;
      fh  = 16'd2;
      for (int i = 0; i < 8; i++) w[i] = rnd168();
      bus.pixs_out_ready = 2'b01;
      send(w[0], 1'b1);
      send(w[1], 1'b0);
      send(w[2], 1'b0);
      chk("bp_w2_valid", bus.pixs_out_valid[1], 1);
      bus.pixs_in       = w[3];
      bus.pixs_in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_core);
         chk("bp_in_ready_low", bus.pixs_in_ready, 0);
         chk("bp_w2_held", lane_data(1), w[2]);
         chk("bp_w2_valid_held", bus.pixs_out_valid[1], 1);
         @(posedge clk_core);
      end
      #1;
      bus.pixs_out_ready = 2'b11;
      @(negedge clk_core);
      chk("bp_in_ready_back", bus.pixs_in_ready, 1);
      @(posedge clk_core);
      #1;
      bus.pixs_in_valid = 1'b0;
      chk("bp_w3_data", lane_data(1), w[3]);
      chk("bp_w3_valid", bus.pixs_out_valid[1], 1);
      for (int i = 4; i < 8; i++) send(w[i], 1'b0);
      chk("bp_frame_done", frame_done, 1);
      chk("bp_lane1_w7", lane_data(1), w[7]);

      // Words without sof in IDLE are swallowed.
      for (int j = 0; j < 3; j++) begin
         bus.pixs_in       = rnd168();
         bus.pixs_in_sof   = 1'b0;
         bus.pixs_in_valid = 1'b1;
         @(negedge clk_core);
         chk("idle_in_ready", bus.pixs_in_ready, 1);
         @(posedge clk_core);
         #1;
         chk("idle_no_valid", bus.pixs_out_valid, 0);
      end
      bus.pixs_in_valid = 1'b0;
      d = rnd168();
      send(d, 1'b1);
      chk("idle_sof_lane0", bus.pixs_out_valid, 2'b01);
      chk("idle_sof_data", lane_data(0), d);
      chk("idle_sof_flag", bus.pixs_out_sof[0], 1);
      send(rnd168(), 1'b0);
      send(rnd168(), 1'b1);
      chk("mid_sof_err", sof_err, 1);
      bus.pixs_out_ready = '0;
      @(posedge clk_core);
      #1;
      chk("pre_reset_hold", bus.pixs_out_valid[0], 1);

      // Asynchronous reset mid-frame.
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("async_reset");
      @(posedge clk_core);
      #1;
      rst_n = 1'b1;
      bus.pixs_out_ready = '1;
      d = rnd168();
      send(d, 1'b1);
      chk("post_reset_lane0", bus.pixs_out_valid, 2'b01);
      chk("post_reset_data", lane_data(0), d);
      flush = 1'b1;
      @(posedge clk_core);
      #1;
      flush = 1'b0;

      // Randomized frames against the reference model.
      for (int f = 0; f < 8; f++) run_random_frame();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
